// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 8-bit shift/rotate unit between N_REQ requesters.
// Define SHIFT_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module shift_arbiter #(
  parameter int N_REQ = 2,
  parameter int LAT   = 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [4*N_REQ-1:0] req_n,
  input  logic [N_REQ-1:0]   req_lr,
  input  logic [N_REQ-1:0]   req_ar,
  input  logic [N_REQ-1:0]   req_rot,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [7:0]         rsp_data
);

  localparam int PTR_W = (N_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, grant, owner;
  logic             found, accept;
  logic [1:0]       cnt;

  logic [7:0]       sel_data;
  logic [3:0]       sel_n;
  logic             sel_lr, sel_ar, sel_rot;

  logic [7:0]       op_data_p0;
  logic [3:0]       op_n_p0;
  logic             op_lr_p0, op_ar_p0, op_rot_p0;

  // Any amount of 8 or more saturates; rotation then degenerates to identity.
  function automatic logic [7:0] shift_op(input logic [7:0] d, input logic [3:0] n,
                                          input logic lr, input logic ar, input logic rot);
    logic signed [7:0] ds;
    logic [15:0]       dd;
    logic [2:0]        r;
    logic [7:0]        res;
    ds = signed'(d);
    dd = {d, d} << (rot && lr && !n[3] ? n[2:0] : 3'd0);
    r  = n[3] ? 3'd0 : n[2:0];
    if (rot) begin
      if (lr) res = dd[15:8];
      else    res = 8'({d, d} >> r);
    end else if (n[3]) begin
      res = (lr || !ar) ? 8'h00 : {8{d[7]}};
    end else if (lr) begin
      res = d << r;
    end else if (ar) begin
      res = 8'(ds >>> r);
    end else begin
      res = d >> r;
    end
    return res;
  endfunction

  always_comb begin
    logic [PTR_W-1:0] idx;
    int               s;
    found    = 1'b0;
    grant    = '0;
    idx      = '0;
    sel_data = '0;
    sel_n    = '0;
    sel_lr   = 1'b0;
    sel_ar   = 1'b0;
    sel_rot  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      s = int'(rr_ptr) + i;
      if (s >= N_REQ) s = s - N_REQ;
      idx = PTR_W'(s);
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        grant    = idx;
        sel_data = req_data[8*idx +: 8];
        sel_n    = req_n[4*idx +: 4];
        sel_lr   = req_lr[idx];
        sel_ar   = req_ar[idx];
        sel_rot  = req_rot[idx];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (found && nrst) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_nxt        = EXEC;
        end
      end
      EXEC: begin
        if (cnt == 2'd0) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      cnt      <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= 2'(LAT - 1);
      end else if (state == EXEC && cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end
      // Last execute cycle: result becomes visible together with rsp_valid.
      if (state == EXEC && cnt == 2'd0) begin
        rsp_data <= shift_op(op_data_p0, op_n_p0, op_lr_p0, op_ar_p0, op_rot_p0);
      end
    end
  end

  // Operand capture at the accept edge; later requester changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_data_p0 <= sel_data;
      op_n_p0    <= sel_n;
      op_lr_p0   <= sel_lr;
      op_ar_p0   <= sel_ar;
      op_rot_p0  <= sel_rot;
      owner      <= grant;
    end
  end

`ifdef SHIFT_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (int'(grant) == N_REQ - 1) ? '0 : grant + PTR_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed spec vectors, randomized ops vs a
// behavioural model, fairness, back-pressure, reset and a LAT=3 timing instance.
module tb_shift_arbiter;

  localparam int N   = 2;
  localparam int LAT = 1;

  logic           clk = 1'b0;
  logic           nrst;
  logic [N-1:0]   req_valid, req_ready, req_lr, req_ar, req_rot, rsp_valid, rsp_ready;
  logic [8*N-1:0] req_data;
  logic [4*N-1:0] req_n;
  logic [7:0]     rsp_data;

  logic [N-1:0]   l3_req_valid, l3_req_ready, l3_req_lr, l3_req_ar, l3_req_rot;
  logic [N-1:0]   l3_rsp_valid, l3_rsp_ready;
  logic [8*N-1:0] l3_req_data;
  logic [4*N-1:0] l3_req_n;
  logic [7:0]     l3_rsp_data;

  always #5 clk = ~clk;

  shift_arbiter #(.N_REQ(N), .LAT(LAT)) u_dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_n(req_n), .req_lr(req_lr), .req_ar(req_ar),
    .req_rot(req_rot), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  shift_arbiter #(.N_REQ(N), .LAT(3)) u_lat3 (
    .clk(clk), .nrst(nrst), .req_valid(l3_req_valid), .req_ready(l3_req_ready),
    .req_data(l3_req_data), .req_n(l3_req_n), .req_lr(l3_req_lr), .req_ar(l3_req_ar),
    .req_rot(l3_req_rot), .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready),
    .rsp_data(l3_rsp_data)
  );

  int checks   = 0;
  int failures = 0;
  int rr       = 0;

  logic [7:0] fd[N];
  logic [3:0] fn[N];
  logic       flr[N], far[N], frot[N];

  typedef struct packed {
    logic [3:0] n;
    logic       lr, ar, rot;
    logic [7:0] want;
  } dir_t;
  dir_t dir[16];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on integers, n saturates at 8.
  function automatic logic [7:0] ref_shift(logic [7:0] d, logic [3:0] n, logic lr, logic ar, logic rot);
    int ne, k, v, p;
    ne = (int'(n) > 8) ? 8 : int'(n);
    p  = 1 << ne;
    v  = int'(d);
    if (rot) begin
      k = ne % 8;
      if (!lr) k = (8 - k) % 8;
      return 8'(((v << k) | (v >> (8 - k))) & 255);
    end
    if (lr) return 8'((v * p) % 256);
    if (!ar || v < 128) return 8'(v / p);
    v = v - 256;
    return 8'(-((-v - 1) / p) - 1);
  endfunction

  function automatic int model_grant(logic [N-1:0] mask);
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (mask[i]) return i;
`else
    for (int i = 0; i < N; i++) if (mask[(rr + i) % N]) return (rr + i) % N;
`endif
    return -1;
  endfunction

  task automatic note_accept(int g);
`ifndef SHIFT_ARB_FIXED_PRIO_EN
    rr = (g + 1) % N;
`endif
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_data[8*i +: 8] = fd[i];
      req_n[4*i +: 4]    = fn[i];
      req_lr[i]          = flr[i];
      req_ar[i]          = far[i];
      req_rot[i]         = frot[i];
    end
  endtask

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      fd[i]   = 8'($urandom);
      fn[i]   = 4'($urandom);
      flr[i]  = 1'($urandom);
      far[i]  = 1'($urandom);
      frot[i] = 1'($urandom);
    end
  endtask

  // One complete op starting in IDLE; want < 0 means use the reference model.
  task automatic issue(logic [N-1:0] mask, int want, string tag);
    int         g;
    logic [7:0] exp;
    g   = model_grant(mask);
    exp = (want < 0) ? ref_shift(fd[g], fn[g], flr[g], far[g], frot[g]) : 8'(want);
    @(negedge clk);
    pack();
    req_valid = mask;
    rsp_ready = '1;
    #1 chk({tag, "_rdy"}, 32'(req_ready), 32'(1 << g));
    @(posedge clk);
    note_accept(g);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = '0;
        rand_fields();
        pack();
      end
      #1 chk({tag, "_busy"}, 32'({rsp_valid, req_ready}), 32'(0));
    end
    @(negedge clk);
    req_valid = '0;
    #1 chk({tag, "_vld"}, 32'(rsp_valid), 32'(1 << g));
    chk({tag, "_data"}, 32'(rsp_data), 32'(exp));
    @(posedge clk);
  endtask

  initial begin
    int         acc_cyc[$], acc_g[$];
    logic [N-1:0] rv[12];
    int         g;
    logic [7:0] exp;

    nrst = 1'b0; req_valid = '1; rsp_ready = '1;
    rand_fields(); pack();
    l3_req_valid = '0; l3_rsp_ready = '1; l3_req_data = '0; l3_req_n = '0;
    l3_req_lr = '0; l3_req_ar = '0; l3_req_rot = '0;
    @(negedge clk);
    #1 chk("rst_rdy", 32'(req_ready), 32'(0));
    chk("rst_vld", 32'(rsp_valid), 32'(0));
    chk("rst_data", 32'(rsp_data), 32'(0));
    nrst = 1'b1; req_valid = '0;

    // Directed vectors, d = 0x96.
    dir[0]  = '{4'd3,  1'b0, 1'b1, 1'b0, 8'hF2};
    dir[1]  = '{4'd3,  1'b0, 1'b0, 1'b0, 8'h12};
    dir[2]  = '{4'd3,  1'b1, 1'b0, 1'b0, 8'hB0};
    dir[3]  = '{4'd3,  1'b1, 1'b0, 1'b1, 8'hB4};
    dir[4]  = '{4'd3,  1'b0, 1'b0, 1'b1, 8'hD2};
    dir[5]  = '{4'd8,  1'b1, 1'b0, 1'b0, 8'h00};
    dir[6]  = '{4'd8,  1'b0, 1'b1, 1'b0, 8'hFF};
    dir[7]  = '{4'd8,  1'b1, 1'b0, 1'b1, 8'h96};
    dir[8]  = '{4'd12, 1'b1, 1'b0, 1'b0, 8'h00};
    dir[9]  = '{4'd12, 1'b0, 1'b1, 1'b0, 8'hFF};
    dir[10] = '{4'd12, 1'b0, 1'b0, 1'b1, 8'h96};
    dir[11] = '{4'd12, 1'b0, 1'b0, 1'b0, 8'h00};
    dir[12] = '{4'd0,  1'b1, 1'b0, 1'b0, 8'h96};
    dir[13] = '{4'd0,  1'b0, 1'b0, 1'b0, 8'h96};
    dir[14] = '{4'd0,  1'b0, 1'b1, 1'b0, 8'h96};
    dir[15] = '{4'd0,  1'b1, 1'b0, 1'b1, 8'h96};
    for (int i = 0; i < 16; i++) begin
      rand_fields();
      fd[i % N] = 8'h96; fn[i % N] = dir[i].n;
      flr[i % N] = dir[i].lr; far[i % N] = dir[i].ar; frot[i % N] = dir[i].rot;
      issue(N'(1 << (i % N)), int'(dir[i].want), $sformatf("dir%0d", i));
    end

    // Randomized ops with random contention, checked against the model.
    for (int i = 0; i < 24; i++) begin
      rand_fields();
      issue(N'($urandom_range(1, (1 << N) - 1)), -1, $sformatf("rnd%0d", i));
    end

    // Fairness: both requesters continuously valid.
    @(negedge clk);
    rand_fields(); pack();
    req_valid = '1; rsp_ready = '1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (req_ready != '0) begin
        acc_cyc.push_back(c);
        acc_g.push_back(req_ready == N'(1) ? 0 : 1);
      end
      rv[c] = rsp_valid;
    end
    req_valid = '0;
    chk("fair_count", 32'(acc_cyc.size()), 32'(4));
    for (int j = 0; j < acc_cyc.size(); j++) begin
      g = model_grant('1);
      note_accept(g);
      chk($sformatf("fair_grant%0d", j), 32'(acc_g[j]), 32'(g));
      if (j > 0) chk($sformatf("fair_gap%0d", j), 32'(acc_cyc[j] - acc_cyc[j-1]), 32'(LAT + 2));
      if (acc_cyc[j] + LAT + 1 < 12)
        chk($sformatf("fair_rsp%0d", j), 32'(rv[acc_cyc[j] + LAT + 1]), 32'(1 << g));
    end
    repeat (LAT + 2) @(negedge clk);

    // Back-pressure: owner holds rsp_ready low, non-owner bit toggled.
    rand_fields();
    exp = ref_shift(fd[0], fn[0], flr[0], far[0], frot[0]);
    @(negedge clk);
    pack(); req_valid = N'(1); rsp_ready = '0;
    #1 chk("bp_rdy", 32'(req_ready), 32'(1));
    @(posedge clk);
    note_accept(0);
    repeat (LAT) @(negedge clk);
    req_valid = N'(2);
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      rsp_ready = N'(2);
      #1 chk("bp_vld", 32'(rsp_valid), 32'(1));
      chk("bp_data", 32'(rsp_data), 32'(exp));
      chk("bp_nordy", 32'(req_ready), 32'(0));
    end
    rsp_ready = '1;
    @(negedge clk);
    #1 chk("bp_release", 32'(req_ready), 32'(2));
    chk("bp_release_vld", 32'(rsp_valid), 32'(0));
    req_valid = '0;
    @(posedge clk);

    // Reset while an op is executing.
    rand_fields();
    @(negedge clk);
    pack(); req_valid = N'(1); rsp_ready = '1;
    #1 chk("rstx_rdy", 32'(req_ready), 32'(1));
    @(posedge clk);
    note_accept(0);
    @(negedge clk);
    nrst = 1'b0; req_valid = N'(2);
    #1 chk("rstx_cycle_rdy", 32'(req_ready), 32'(0));
    @(negedge clk);
    rr = 0;
    #1 chk("rstx_vld", 32'(rsp_valid), 32'(0));
    chk("rstx_data", 32'(rsp_data), 32'(0));
    chk("rstx_nordy", 32'(req_ready), 32'(0));
    nrst = 1'b1; req_valid = '1;
    #1 chk("rstx_ptr", 32'(req_ready), 32'(1));
    req_valid = '0;
    #1 chk("rstx_norsp", 32'(rsp_valid), 32'(0));
    rand_fields();
    issue(N'(2), -1, "rstx_req1");

    // LAT=3 instance: response exactly four cycles after the accept cycle.
    @(negedge clk);
    l3_req_valid = N'(1); l3_req_data = {8'h00, 8'h96}; l3_req_n = {4'd0, 4'd3};
    l3_req_lr = N'(1);
    #1 chk("lat3_rdy", 32'(l3_req_ready), 32'(1));
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      l3_req_valid = '0; l3_req_data = '0;
      #1 chk($sformatf("lat3_early%0d", k), 32'(l3_rsp_valid), 32'(0));
    end
    @(negedge clk);
    #1 chk("lat3_vld", 32'(l3_rsp_valid), 32'(1));
    chk("lat3_data", 32'(l3_rsp_data), 32'(8'hB0));
    @(negedge clk);
    #1 chk("lat3_done", 32'(l3_rsp_valid), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
